// File: rtl/id_imm_ctrl_pkg.sv
// id_imm_ctrl_pkg: extension op codes, LA32R opcode constants, entry layout and decode table
package id_imm_ctrl_pkg;

    typedef enum logic [2:0] {
        EXT_OP_NONE  = 3'd0,
        EXT_OP_IMM12 = 3'd1,
        EXT_OP_IMM16 = 3'd2,
        EXT_OP_IMM28 = 3'd3
    } ext_op_e;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } occ_e;

    // 10-bit major opcodes, inst[31:22]
    localparam logic [9:0] OPC_SLTI   = 10'h008;
    localparam logic [9:0] OPC_SLTUI  = 10'h009;
    localparam logic [9:0] OPC_ADDI_W = 10'h00A;
    localparam logic [9:0] OPC_LD_B   = 10'h0A0;
    localparam logic [9:0] OPC_LD_H   = 10'h0A1;
    localparam logic [9:0] OPC_LD_W   = 10'h0A2;
    localparam logic [9:0] OPC_ST_B   = 10'h0A4;
    localparam logic [9:0] OPC_ST_H   = 10'h0A5;
    localparam logic [9:0] OPC_ST_W   = 10'h0A6;
    localparam logic [9:0] OPC_LD_BU  = 10'h0A8;
    localparam logic [9:0] OPC_LD_HU  = 10'h0A9;

    // 6-bit major opcodes, inst[31:26]
    localparam logic [5:0] OPC_JIRL = 6'h13;
    localparam logic [5:0] OPC_B    = 6'h14;
    localparam logic [5:0] OPC_BL   = 6'h15;
    localparam logic [5:0] OPC_BEQ  = 6'h16;
    localparam logic [5:0] OPC_BNE  = 6'h17;
    localparam logic [5:0] OPC_BLT  = 6'h18;
    localparam logic [5:0] OPC_BGE  = 6'h19;
    localparam logic [5:0] OPC_BLTU = 6'h1A;
    localparam logic [5:0] OPC_BGEU = 6'h1B;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        ext_op_e     op;
        logic [31:0] imm;
        logic        no_imm;
    } entry_t;

    function automatic ext_op_e decode_op(input logic [31:0] inst);
        return (inst[31:22] inside {OPC_SLTI, OPC_SLTUI, OPC_ADDI_W, OPC_LD_B, OPC_LD_H, OPC_LD_W,
                                    OPC_ST_B, OPC_ST_H, OPC_ST_W, OPC_LD_BU, OPC_LD_HU}) ? EXT_OP_IMM12 :
               (inst[31:26] inside {OPC_JIRL, OPC_BEQ, OPC_BNE, OPC_BLT, OPC_BGE,
                                    OPC_BLTU, OPC_BGEU})                            ? EXT_OP_IMM16 :
               (inst[31:26] inside {OPC_B, OPC_BL})                                 ? EXT_OP_IMM28 :
                                                                                      EXT_OP_NONE;
    endfunction

endpackage

// File: rtl/id_imm_ctrl_if.sv
// id_imm_ctrl_if: IF->ID and ID->EX handshake bundle for the decode-stage immediate controller
interface id_imm_ctrl_if;
    import id_imm_ctrl_pkg::*;

    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    ext_op_e     id_sext1_op;
    logic [31:0] id_imm;
    logic        id_no_imm;

    modport master (
        output if_valid, if_inst, if_pc, id_ready,
        input  if_ready, id_valid, id_inst, id_pc, id_sext1_op, id_imm, id_no_imm
    );

    modport slave (
        input  if_valid, if_inst, if_pc, id_ready,
        output if_ready, id_valid, id_inst, id_pc, id_sext1_op, id_imm, id_no_imm
    );
endinterface

// File: rtl/id_imm_ctrl_sext1.sv
// id_imm_ctrl_sext1: LA32R immediate extraction and sign extension for the decoded op
module id_imm_ctrl_sext1
    import id_imm_ctrl_pkg::*;
(
    input  ext_op_e     i_op,
    input  logic [25:0] i_field,
    output logic [31:0] o_imm
);

    // si12, offs16<<2 and {offs26}<<2 (offs26 = inst[9:0]:inst[25:10]) sign-extended
    always_comb begin
        o_imm = (i_op == EXT_OP_IMM12) ? {{20{i_field[21]}}, i_field[21:10]} :
                (i_op == EXT_OP_IMM16) ? {{14{i_field[25]}}, i_field[25:10], 2'b00} :
                (i_op == EXT_OP_IMM28) ? {{4{i_field[9]}}, i_field[9:0], i_field[25:10], 2'b00} :
                                         32'd0;
    end

endmodule

// File: rtl/id_imm_ctrl.sv
// id_imm_ctrl: decode-stage immediate controller with 2-entry skid buffer and stall counter
module id_imm_ctrl
    import id_imm_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             cpu_clk,
    input  logic             cpu_rstn,
    input  logic             flush,
    id_imm_ctrl_if.slave     bus,
    output logic [CNT_W-1:0] stall_cnt
);

    occ_e             r_state;
    occ_e             w_state_n;
    entry_t           r_main;
    entry_t           r_skid;
    entry_t           w_in;
    logic             r_if_ready;
    logic [CNT_W-1:0] r_stall;
    ext_op_e          w_op;
    logic [31:0]      w_imm;
    logic             w_acc;
    logic             w_emit;
    logic             w_ld_in;
    logic             w_ld_skid;
    logic             w_ld_from_skid;

    assign w_op = decode_op(bus.if_inst);

    id_imm_ctrl_sext1 u_sext1 (
        .i_op   (w_op),
        .i_field(bus.if_inst[25:0]),
        .o_imm  (w_imm)
    );

    assign w_in   = {bus.if_inst, bus.if_pc, w_op, w_imm, (w_op == EXT_OP_NONE)};
    assign w_acc  = bus.if_valid & r_if_ready;
    assign w_emit = bus.id_valid & bus.id_ready;

    assign bus.if_ready    = r_if_ready;
    assign bus.id_valid    = (r_state != ST_EMPTY);
    assign bus.id_inst     = r_main.inst;
    assign bus.id_pc       = r_main.pc;
    assign bus.id_sext1_op = r_main.op;
    assign bus.id_imm      = r_main.imm;
    assign bus.id_no_imm   = r_main.no_imm;
    assign stall_cnt       = r_stall;

    // occupancy next state and entry load selects; flush overrides every transition
    always_comb begin
        w_state_n      = r_state;
        w_ld_in        = 1'b0;
        w_ld_skid      = 1'b0;
        w_ld_from_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                w_state_n = w_acc ? ST_ONE : ST_EMPTY;
                w_ld_in   = w_acc;
            end
            ST_ONE: begin
                w_state_n = (w_acc & !w_emit) ? ST_TWO :
                            (w_emit & !w_acc) ? ST_EMPTY : ST_ONE;
                w_ld_in   = w_acc & w_emit;
                w_ld_skid = w_acc & !w_emit;
            end
            ST_TWO: begin
                w_state_n      = w_emit ? ST_ONE : ST_TWO;
                w_ld_from_skid = w_emit;
            end
            default: w_state_n = ST_EMPTY;
        endcase
        if (flush) begin
            w_state_n      = ST_EMPTY;
            w_ld_in        = 1'b0;
            w_ld_skid      = 1'b0;
            w_ld_from_skid = 1'b0;
        end
    end

    // state register; if_ready is registered from the next state so it never depends on id_ready
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn) begin
            r_state    <= ST_EMPTY;
            r_if_ready <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_if_ready <= (w_state_n != ST_TWO);
        end
    end

    // main entry drives id_*, skid entry parks the second instruction while EX stalls
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_ld_in)
                r_main <= w_in;
            else if (w_ld_from_skid)
                r_main <= r_skid;
            if (w_ld_skid)
                r_skid <= w_in;
        end
    end

    // saturating count of cycles EX back-pressures a valid instruction
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn)
            r_stall <= '0;
        else if (bus.id_valid & !bus.id_ready & !flush & (r_stall != {CNT_W{1'b1}}))
            r_stall <= r_stall + 1'b1;
    end

endmodule

// File: tb/tb_id_imm_ctrl.sv
// tb_id_imm_ctrl: directed self-checking bench for the decode-stage immediate controller
module tb_id_imm_ctrl;
    import id_imm_ctrl_pkg::*;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic [15:0] stall_cnt;
    logic [3:0]  stall4;
    int          n_chk;
    int          n_fail;

    id_imm_ctrl_if bus ();
    id_imm_ctrl_if bus4 ();

    assign bus4.if_valid = bus.if_valid;
    assign bus4.if_inst  = bus.if_inst;
    assign bus4.if_pc    = bus.if_pc;
    assign bus4.id_ready = bus.id_ready;

    id_imm_ctrl u_dut (
        .cpu_clk  (clk),
        .cpu_rstn (rstn),
        .flush    (flush),
        .bus      (bus),
        .stall_cnt(stall_cnt)
    );

    id_imm_ctrl #(.CNT_W(4)) u_dut4 (
        .cpu_clk  (clk),
        .cpu_rstn (rstn),
        .flush    (flush),
        .bus      (bus4),
        .stall_cnt(stall4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " if_ready"}, 32'(bus.if_ready), 32'd0);
        check({tag, " id_valid"}, 32'(bus.id_valid), 32'd0);
        check({tag, " id_inst"}, bus.id_inst, 32'd0);
        check({tag, " id_pc"}, bus.id_pc, 32'd0);
        check({tag, " id_imm"}, bus.id_imm, 32'd0);
        check({tag, " op"}, 32'(bus.id_sext1_op), 32'(EXT_OP_NONE));
        check({tag, " no_imm"}, 32'(bus.id_no_imm), 32'd0);
        check({tag, " stall"}, 32'(stall_cnt), 32'd0);
        check({tag, " stall4"}, 32'(stall4), 32'd0);
    endtask

    localparam logic [31:0] INST_A = 32'h0280_0400; // addi.w si12=1
    localparam logic [31:0] INST_B = 32'h5C00_0400; // bne offs16=1 -> 4
    localparam logic [31:0] INST_D = 32'h5400_0800; // bl

    logic [31:0] v_inst [3];
    logic [31:0] v_imm  [3];
    ext_op_e     v_op   [3];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        v_inst = '{32'h53FF_FFFF, 32'h5400_0800, 32'h5A00_0000};
        v_imm  = '{32'hFFFF_FFFC, 32'h0000_0008, 32'hFFFE_0000};
        v_op   = '{EXT_OP_IMM28, EXT_OP_IMM28, EXT_OP_IMM16};
        rstn = 1'b0;
        flush = 1'b0;
        bus.if_valid = 1'b0;
        bus.if_inst = '0;
        bus.if_pc = '0;
        bus.id_ready = 1'b0;
        cyc();
        cyc();
        check_reset_outputs("por");
        rstn = 1'b1;
        cyc();
        check("post-reset if_ready", 32'(bus.if_ready), 32'd1);
        check("post-reset id_valid", 32'(bus.id_valid), 32'd0);

        // single addi.w, one-cycle latency
        bus.id_ready = 1'b1;
        bus.if_valid = 1'b1;
        bus.if_inst = 32'h02BF_FC01;
        bus.if_pc = 32'h0000_1000;
        cyc();
        bus.if_valid = 1'b0;
        check("addi id_valid", 32'(bus.id_valid), 32'd1);
        check("addi op", 32'(bus.id_sext1_op), 32'(EXT_OP_IMM12));
        check("addi imm", bus.id_imm, 32'hFFFF_FFFF);
        check("addi inst", bus.id_inst, 32'h02BF_FC01);
        check("addi pc", bus.id_pc, 32'h0000_1000);
        check("addi no_imm", 32'(bus.id_no_imm), 32'd0);
        check("addi if_ready", 32'(bus.if_ready), 32'd1);
        cyc();
        check("addi drained", 32'(bus.id_valid), 32'd0);

        // back-to-back branches at full throughput
        for (int i = 0; i < 3; i++) begin
            bus.if_valid = 1'b1;
            bus.if_inst = v_inst[i];
            bus.if_pc = 32'h0000_2000 + 32'(i * 4);
            cyc();
            check("b2b id_valid", 32'(bus.id_valid), 32'd1);
            check("b2b inst", bus.id_inst, v_inst[i]);
            check("b2b imm", bus.id_imm, v_imm[i]);
            check("b2b op", 32'(bus.id_sext1_op), 32'(v_op[i]));
            check("b2b if_ready", 32'(bus.if_ready), 32'd1);
        end
        bus.if_valid = 1'b0;
        cyc();
        check("b2b drained", 32'(bus.id_valid), 32'd0);

        // fill both entries under back-pressure, hold, then release
        bus.id_ready = 1'b0;
        bus.if_valid = 1'b1;
        bus.if_inst = INST_A;
        bus.if_pc = 32'h0000_3000;
        cyc();
        bus.if_inst = INST_B;
        bus.if_pc = 32'h0000_3004;
        cyc();
        bus.if_valid = 1'b0;
        check("full if_ready", 32'(bus.if_ready), 32'd0);
        check("full stall", 32'(stall_cnt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("hold inst", bus.id_inst, INST_A);
            check("hold imm", bus.id_imm, 32'h0000_0001);
        end
        check("hold stall", 32'(stall_cnt), 32'd5);
        bus.id_ready = 1'b1;
        cyc();
        check("rel1 inst", bus.id_inst, INST_B);
        check("rel1 pc", bus.id_pc, 32'h0000_3004);
        check("rel1 imm", bus.id_imm, 32'h0000_0004);
        check("rel1 op", 32'(bus.id_sext1_op), 32'(EXT_OP_IMM16));
        check("rel1 if_ready", 32'(bus.if_ready), 32'd1);
        check("rel1 stall", 32'(stall_cnt), 32'd5);
        cyc();
        check("rel2 id_valid", 32'(bus.id_valid), 32'd0);

        // flush while full and IF offers a third instruction
        bus.id_ready = 1'b0;
        bus.if_valid = 1'b1;
        bus.if_inst = INST_A;
        cyc();
        bus.if_inst = INST_B;
        cyc();
        check("pre-flush stall", 32'(stall_cnt), 32'd6);
        bus.if_inst = INST_D;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        bus.if_valid = 1'b0;
        check("flush id_valid", 32'(bus.id_valid), 32'd0);
        check("flush if_ready", 32'(bus.if_ready), 32'd1);
        check("flush stall", 32'(stall_cnt), 32'd6);
        cyc();
        check("flush no third", 32'(bus.id_valid), 32'd0);
        check("flush main kept", bus.id_inst, INST_A);

        // opcode outside the immediate table
        bus.id_ready = 1'b1;
        bus.if_valid = 1'b1;
        bus.if_inst = 32'h0010_0000;
        bus.if_pc = 32'h0000_4000;
        cyc();
        bus.if_valid = 1'b0;
        check("add.w id_valid", 32'(bus.id_valid), 32'd1);
        check("add.w op", 32'(bus.id_sext1_op), 32'(EXT_OP_NONE));
        check("add.w imm", bus.id_imm, 32'd0);
        check("add.w no_imm", 32'(bus.id_no_imm), 32'd1);
        cyc();

        // reset while full
        bus.id_ready = 1'b0;
        bus.if_valid = 1'b1;
        bus.if_inst = INST_A;
        cyc();
        bus.if_inst = INST_B;
        cyc();
        bus.if_valid = 1'b0;
        check("pre-reset stall", 32'(stall_cnt), 32'd7);
        rstn = 1'b0;
        cyc();
        check_reset_outputs("rst-in-two");
        rstn = 1'b1;
        cyc();
        check("rst-in-two if_ready", 32'(bus.if_ready), 32'd1);

        // long stall saturates the narrow counter only
        bus.if_valid = 1'b1;
        bus.if_inst = INST_A;
        cyc();
        bus.if_valid = 1'b0;
        repeat (20) cyc();
        check("sat stall16", 32'(stall_cnt), 32'd20);
        check("sat stall4", 32'(stall4), 32'd15);
        bus.id_ready = 1'b1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
